inst_memory: RTL and testbench

Word-addressed instruction memory that acts as the responder on the instruction-fetch handshake (address/valid in, data/ready out) driven by the core's fetch stage. It holds the program in an internal synchronous RAM, returns one 32-bit word per accepted request after a fixed, parameterised latency, and accepts program writes from a loader port (UART/boot loader) in any cycle. It also flags misaligned or out-of-range fetches and counts completed fetches for debug.

---
 rtl/inst_memory.sv | 144 ++++++++++++++
 tb/tb_inst_memory.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_memory.sv
// Instruction memory responding to the fetch-stage handshake with a fixed response latency.
// Also flags misaligned/out-of-range fetches, accepts loader writes in any cycle and counts completed fetches.
module inst_memory #(
   parameter int DEPTH_LOG2 = 12,
   parameter int LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           inst_mem_out_addr,
   input  logic                  inst_mem_out_valid,
   output logic [31:0]           inst_mem_out_data,
   output logic                  inst_mem_out_ready,
   output logic                  fetch_fault,
   input  logic                  load_valid,
   input  logic [DEPTH_LOG2-1:0] load_addr,
   input  logic [31:0]           load_data,
   output logic [31:0]           fetch_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   logic [31:0]           ram [0:(1 << DEPTH_LOG2) - 1];
   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0] idx_q, idx_d;
   logic                  bad_q, bad_d;
   logic                  ready_q, ready_d;
   logic                  fault_q, fault_d;
   logic [31:0]           count_q, count_d;
   logic [31:0]           data_q;
   logic                  rd_en;
   logic                  req_bad;

   // Fault when the byte address is not word aligned or points past the last RAM word.
   always_comb begin
      req_bad = (inst_mem_out_addr[1:0] != 2'b00) ||
                ((inst_mem_out_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
   end

   // Next-state logic; the RAM is read on the edge that enters S_RESP, and never for a faulting request.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      bad_d   = bad_q;
      rd_en   = 1'b0;
      fault_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (inst_mem_out_valid) begin
               idx_d = inst_mem_out_addr[DEPTH_LOG2+1:2];
               bad_d = req_bad;
               if (LATENCY == 1) begin
                  state_d = S_RESP;
                  rd_en   = !req_bad;
                  fault_d = req_bad;
               end else begin
                  cnt_d   = LAT_M1;
                  state_d = S_WAIT;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            // Dropping valid abandons the request, even on the edge the counter would expire.
            if (!inst_mem_out_valid) begin
               cnt_d   = 4'd0;
               state_d = S_IDLE;
            end else if (cnt_q == 4'd1) begin
               cnt_d   = 4'd0;
               state_d = S_RESP;
               rd_en   = !bad_q;
               fault_d = bad_q;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      ready_d = (state_d == S_RESP);
      if (state_q == S_RESP) begin
         count_d = count_q + 32'd1;
      end else begin
         count_d = count_q;
      end
   end

   // Control and status registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         bad_q   <= 1'b0;
         ready_q <= 1'b0;
         fault_q <= 1'b0;
         count_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         bad_q   <= bad_d;
         ready_q <= ready_d;
         fault_q <= fault_d;
         count_q <= count_d;
      end
   end

   // Loader write port; deliberately not gated by reset so boot loads are never lost.
   always_ff @(posedge clk) begin
      if (load_valid) begin
         ram[load_addr] <= load_data;
      end
   end

   // Registered read port; nonblocking semantics give read-before-write against the loader.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= 32'd0;
      end else if (rd_en) begin
         data_q <= ram[idx_d];
      end else begin
         data_q <= 32'd0;
      end
   end

   assign inst_mem_out_data  = data_q;
   assign inst_mem_out_ready = ready_q;
   assign fetch_fault        = fault_q;
   assign fetch_count        = count_q;

endmodule

// File: tb/tb_inst_memory.sv
// Bench for inst_memory: a LATENCY=2 and a LATENCY=1 instance sharing one loader, checked
// against an array model of the RAM and the fetch latency/fault rules.
module tb_inst_memory;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] addr0 = 32'd0, addr1 = 32'd0;
   logic        valid0 = 1'b0, valid1 = 1'b0;
   logic [31:0] data0, data1;
   logic        ready0, ready1, fault0, fault1;
   logic        load_valid = 1'b0;
   logic [11:0] load_addr = 12'd0;
   logic [31:0] load_data = 32'd0;
   logic [31:0] count0, count1;

   logic [31:0] mem_m [0:4095];
   int          cnt0 = 0, cnt1 = 0;
   int          tests = 0, fails = 0;

   always #5 clk = ~clk;

   inst_memory #(.DEPTH_LOG2(12), .LATENCY(2)) u_dut (
      .clk(clk), .reset(reset),
      .inst_mem_out_addr(addr0), .inst_mem_out_valid(valid0),
      .inst_mem_out_data(data0), .inst_mem_out_ready(ready0), .fetch_fault(fault0),
      .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
      .fetch_count(count0)
   );

   inst_memory #(.DEPTH_LOG2(12), .LATENCY(1)) u_dut1 (
      .clk(clk), .reset(reset),
      .inst_mem_out_addr(addr1), .inst_mem_out_valid(valid1),
      .inst_mem_out_data(data1), .inst_mem_out_ready(ready1), .fetch_fault(fault1),
      .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
      .fetch_count(count1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [11:0] idx, input logic [31:0] d);
      load_valid = 1'b1;
      load_addr  = idx;
      load_data  = d;
      tick();
      load_valid = 1'b0;
      mem_m[idx] = d;
   endtask

   // One complete fetch on instance 'which' with valid held until ready, then dropped.
   task automatic fetch(input int which, input logic [31:0] a);
      logic [31:0] exp_d;
      logic        exp_f;
      logic        got;
      logic [31:0] got_d;
      logic        got_f;
      int          cyc;
      exp_f = (a[1:0] != 2'b00) || (a >= 32'h0000_4000);
      exp_d = exp_f ? 32'd0 : mem_m[a[13:2]];
      if (which == 0) begin
         valid0 = 1'b1; addr0 = a;
      end else begin
         valid1 = 1'b1; addr1 = a;
      end
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 20) begin
         tick();
         cyc++;
         got = (which == 0) ? ready0 : ready1;
      end
      got_d = (which == 0) ? data0 : data1;
      got_f = (which == 0) ? fault0 : fault1;
      check("fetch_latency", 32'(cyc), (which == 0) ? 32'd2 : 32'd1);
      check("fetch_data", got_d, exp_d);
      check("fetch_fault", {31'd0, got_f}, {31'd0, exp_f});
      valid0 = 1'b0;
      valid1 = 1'b0;
      tick();
      check("ready_one_cycle", {31'd0, (which == 0) ? ready0 : ready1}, 32'd0);
      if (which == 0) begin
         cnt0++;
         check("fetch_count0", count0, 32'(cnt0));
      end else begin
         cnt1++;
         check("fetch_count1", count1, 32'(cnt1));
      end
   endtask

   initial begin
      int unsigned r;
      int unsigned kind;
      logic [31:0] a;

      // Reset state
      repeat (3) tick();
      reset = 1'b0;
      check("rst_ready", {31'd0, ready0}, 32'd0);
      check("rst_data", data0, 32'd0);
      check("rst_fault", {31'd0, fault0}, 32'd0);
      check("rst_count", count0, 32'd0);
      check("rst_count1", count1, 32'd0);

      for (int i = 0; i < 64; i++) load(12'(i), $urandom);

      // Basic fetches
      load(12'd0, 32'h2001_0005);
      load(12'd1, 32'h8C22_0000);
      fetch(0, 32'h0);
      fetch(0, 32'h4);

      // Valid held high: one-cycle pulses every LATENCY+1 cycles
      valid0 = 1'b1;
      addr0  = 32'h4;
      for (int k = 1; k <= 15; k++) begin
         tick();
         check("hold_ready", {31'd0, ready0}, (k % 3 == 2) ? 32'd1 : 32'd0);
         if (k % 3 == 2) check("hold_data", data0, mem_m[1]);
      end
      valid0 = 1'b0;
      cnt0 += 5;
      tick();
      check("hold_count", count0, 32'(cnt0));

      // Faults, then RAM unchanged
      fetch(0, 32'h2);
      fetch(0, 32'h4000);
      fetch(1, 32'h8000_0000);
      fetch(0, 32'h0);
      fetch(0, 32'h4);

      // Load on the RAM-read edge is not visible; a later re-fetch sees it
      load(12'd3, 32'h1111_1111);
      valid0 = 1'b1;
      addr0  = 32'hC;
      tick();
      load_valid = 1'b1; load_addr = 12'd3; load_data = 32'h2222_2222;
      tick();
      load_valid = 1'b0;
      check("rbw_ready", {31'd0, ready0}, 32'd1);
      check("rbw_data", data0, 32'h1111_1111);
      mem_m[3] = 32'h2222_2222;
      valid0 = 1'b0;
      tick();
      cnt0++;
      fetch(0, 32'hC);

      // Load on the acceptance edge is visible
      valid0 = 1'b1; addr0 = 32'h10;
      load_valid = 1'b1; load_addr = 12'd4; load_data = 32'hCAFE_0004;
      tick();
      load_valid = 1'b0;
      tick();
      check("early_load_data", data0, 32'hCAFE_0004);
      mem_m[4] = 32'hCAFE_0004;
      valid0 = 1'b0;
      tick();
      cnt0++;

      // Reset during WAIT drops the request; a load with reset still lands
      valid0 = 1'b1; addr0 = 32'h0;
      tick();
      reset = 1'b1;
      load_valid = 1'b1; load_addr = 12'd5; load_data = 32'hA5A5_0005;
      tick();
      reset = 1'b0;
      load_valid = 1'b0;
      valid0 = 1'b0;
      mem_m[5] = 32'hA5A5_0005;
      cnt0 = 0;
      cnt1 = 0;
      for (int k = 0; k < 4; k++) begin
         check("rst_wait_ready", {31'd0, ready0}, 32'd0);
         tick();
      end
      check("rst_wait_count", count0, 32'd0);
      check("rst_wait_count1", count1, 32'd0);
      fetch(0, 32'h0);
      fetch(0, 32'h14);

      // Drop valid during WAIT: abandoned, then next request takes full latency
      valid0 = 1'b1; addr0 = 32'h8;
      tick();
      valid0 = 1'b0;
      tick();
      check("drop_ready", {31'd0, ready0}, 32'd0);
      tick();
      check("drop_ready2", {31'd0, ready0}, 32'd0);
      check("drop_count", count0, 32'(cnt0));
      fetch(0, 32'h8);
      fetch(1, 32'h8);

      // Randomized loads and fetches on both instances
      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 9);
         if (r < 3) begin
            load(12'($urandom_range(0, 63)), $urandom);
         end else begin
            kind = $urandom_range(0, 3);
            if (kind < 2) a = 32'($urandom_range(0, 63)) << 2;
            else if (kind == 2) a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
            else a = $urandom_range(32'hFFFF_FFFF, 32'h0000_4000);
            fetch(int'($urandom_range(0, 1)), a);
            repeat ($urandom_range(0, 2)) tick();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
